// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, FSM state encoding and opcode classifiers.
// The combinational alu and the sequential alu_seq both import this package.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_SRL   = 4'b1101;
    localparam logic [3:0] OP_SRA   = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    function automatic logic is_single_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU: r = 1'b1;
            default:                                 r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Bit-serial shift-add unsigned multiplier producing a full 2*WIDTH product.
// Bit 0 is folded in on the start edge, the remaining WIDTH-1 bits while busy.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state for one shift-add step; done pulses for one cycle after the last bit.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : {(2*WIDTH){1'b0}};
            mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_d = {1'b0, b[WIDTH-1:1]};
            cnt_d    = CW'(WIDTH - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= {(2*WIDTH){1'b0}};
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops finish in one cycle, MUL/MULHU use a sequential
// multiplier; the result is held in DONE until the consumer takes it.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    localparam int   SHW    = $clog2(WIDTH);
    localparam logic MUL_ON = (MUL_EN != 0);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               illegal_q, illegal_d;
    logic               mul_hi_q, mul_hi_d;
    logic               mul_start_s;
    logic               mul_busy_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;

    function automatic logic [WIDTH-1:0] alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] one;
        logic [WIDTH-1:0] r;
        sh  = b[SHW-1:0];
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = $signed(a) >>> sh;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? one : {WIDTH{1'b0}};
            OP_SLTU: r = (a < b) ? one : {WIDTH{1'b0}};
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst_n   (rst_n),
                .start   (mul_start_s),
                .a       (left),
                .b       (right),
                .busy    (mul_busy_s),
                .done    (mul_done_s),
                .product (mul_prod_s)
            );
        end else begin : g_no_mul
            assign mul_busy_s = 1'b0;
            assign mul_done_s = 1'b0;
            assign mul_prod_s = {(2*WIDTH){1'b0}};
        end
    endgenerate

    // FSM next-state; the single-cycle result is computed at acceptance so later input changes cannot leak in.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        illegal_d   = illegal_q;
        mul_hi_d    = mul_hi_q;
        mul_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul_op(opcode) && MUL_ON) begin
                        mul_start_s = 1'b1;
                        mul_hi_d    = (opcode == OP_MULHU);
                        state_d     = ST_BUSY;
                    end else if (is_single_op(opcode)) begin
                        result_d    = alu_eval(opcode, left, right);
                        illegal_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        result_d    = {WIDTH{1'b0}};
                        illegal_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_done_s) begin
                    result_d    = mul_hi_q ? mul_prod_s[2*WIDTH-1:WIDTH] : mul_prod_s[WIDTH-1:0];
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (!mul_busy_s) begin
                    // Multiplier lost its operation (should not happen): drop back rather than hang.
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                result_d    = {WIDTH{1'b0}};
                illegal_d   = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            illegal_q   <= 1'b0;
            mul_hi_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
            mul_hi_q    <= mul_hi_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table plus hand-written reset, backpressure
// and MUL_EN=0 sequences.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, illegal;
    logic [3:0]  opcode;
    logic [31:0] left, right, result;

    logic        nm_in_valid, nm_in_ready, nm_out_valid, nm_out_ready, nm_illegal;
    logic [3:0]  nm_opcode;
    logic [31:0] nm_left, nm_right, nm_result;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        ill;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    alu_seq #(.WIDTH(32), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .left(left), .right(right), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .illegal(illegal)
    );

    alu_seq #(.WIDTH(32), .MUL_EN(0)) dut_nm (
        .clk(clk), .rst_n(rst_n), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
        .opcode(nm_opcode), .left(nm_left), .right(nm_right), .out_valid(nm_out_valid),
        .out_ready(nm_out_ready), .result(nm_result), .illegal(nm_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge with the block idle again.
    task automatic run_op(input vec_t v);
        int  lat;
        int  rdy_bad;
        bit  seen;
        chk({v.nm, " in_ready before"}, {31'd0, in_ready}, 32'd1);
        opcode   = v.op;
        left     = v.a;
        right    = v.b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode   = 4'h0;
        left     = $urandom();
        right    = $urandom();
        lat      = 1;
        seen     = 1'b0;
        rdy_bad  = 0;
        while (!seen && lat <= 100) begin
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                if (in_ready) rdy_bad++;
                @(posedge clk); #1;
                lat++;
            end
        end
        chk({v.nm, " out_valid seen"}, {31'd0, seen}, 32'd1);
        chk({v.nm, " latency"}, lat, v.lat);
        chk({v.nm, " result"}, result, v.exp);
        chk({v.nm, " illegal"}, {31'd0, illegal}, {31'd0, v.ill});
        chk({v.nm, " in_ready low while busy"}, rdy_bad, 32'd0);
        chk({v.nm, " in_ready low in done"}, {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({v.nm, " out_valid dropped"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int hi_cnt;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; opcode = 4'h0; left = 32'd0; right = 32'd0;
        nm_in_valid = 1'b0; nm_out_ready = 1'b0; nm_opcode = 4'h0; nm_left = 32'd0; nm_right = 32'd0;

        vecs.push_back('{OP_ADD,   32'd4,        32'd3,        32'd7,        1'b0, 1,  "ADD 4,3"});
        vecs.push_back('{OP_SUB,   32'd7,        32'd3,        32'd4,        1'b0, 1,  "SUB 7,3"});
        vecs.push_back('{OP_SUB,   32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1,  "SUB 0,1"});
        vecs.push_back('{OP_ADD,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1,  "ADD wrap"});
        vecs.push_back('{OP_AND,   32'hC,        32'hA,        32'h8,        1'b0, 1,  "AND"});
        vecs.push_back('{OP_OR,    32'hC,        32'hA,        32'hE,        1'b0, 1,  "OR"});
        vecs.push_back('{OP_XOR,   32'hC,        32'hA,        32'h6,        1'b0, 1,  "XOR"});
        vecs.push_back('{OP_SLL,   32'd1,        32'h24,       32'h10,       1'b0, 1,  "SLL by 0x24"});
        vecs.push_back('{OP_SRL,   32'h80000000, 32'd31,       32'd1,        1'b0, 1,  "SRL 31"});
        vecs.push_back('{OP_SRA,   32'h80000000, 32'h21,       32'hC0000000, 1'b0, 1,  "SRA neg by 0x21"});
        vecs.push_back('{OP_SRA,   32'h40000000, 32'h1E,       32'd1,        1'b0, 1,  "SRA pos"});
        vecs.push_back('{OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1,  "SLT -1,1"});
        vecs.push_back('{OP_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1,  "SLTU"});
        vecs.push_back('{OP_SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 1,  "SLT 1,-1"});
        vecs.push_back('{OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, 33, "MUL max"});
        vecs.push_back('{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, "MULHU max"});
        vecs.push_back('{OP_MUL,   32'd7,        32'd6,        32'd42,       1'b0, 33, "MUL 7,6"});
        vecs.push_back('{OP_MUL,   32'h10000,    32'h10000,    32'd0,        1'b0, 33, "MUL 2^32 lo"});
        vecs.push_back('{OP_MULHU, 32'h10000,    32'h10000,    32'd1,        1'b0, 33, "MULHU 2^32 hi"});
        vecs.push_back('{4'b1111,  32'd5,        32'd6,        32'd0,        1'b1, 1,  "opcode 1111"});
        vecs.push_back('{4'b1010,  32'd5,        32'd6,        32'd0,        1'b1, 1,  "opcode 1010"});

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset illegal", {31'd0, illegal}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i]);

        // Backpressure: result held for 5 cycles with out_ready low.
        opcode = OP_ADD; left = 32'd1; right = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; left = 32'd99; right = 32'd99;
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid held", {31'd0, out_valid}, 32'd1);
            chk("bp result held", result, 32'd2);
            chk("bp in_ready low", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp idle after take", {31'd0, in_ready}, 32'd1);
        chk("bp out_valid cleared", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a multiply.
        opcode = OP_MUL; left = 32'd3; right = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst busy out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst busy in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hi_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) hi_cnt++;
            @(posedge clk); #1;
        end
        chk("rst busy no stale result", hi_cnt, 32'd0);
        run_op('{OP_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1, "ADD 2,2 after reset"});

        // Reset while a result is waiting in DONE.
        opcode = OP_ADD; left = 32'd5; right = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre-rst done result", result, 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst done out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst done result", result, 32'd0);
        chk("rst done in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op('{OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1, "XOR after reset"});

        // MUL_EN=0 build: MUL is illegal with latency 1, ADD still legal.
        nm_opcode = OP_MUL; nm_left = 32'd3; nm_right = 32'd4; nm_in_valid = 1'b1;
        @(posedge clk); #1;
        nm_in_valid = 1'b0;
        chk("nomul MUL out_valid lat1", {31'd0, nm_out_valid}, 32'd1);
        chk("nomul MUL illegal", {31'd0, nm_illegal}, 32'd1);
        chk("nomul MUL result", nm_result, 32'd0);
        nm_out_ready = 1'b1;
        @(posedge clk); #1;
        nm_out_ready = 1'b0;
        chk("nomul idle", {31'd0, nm_in_ready}, 32'd1);
        nm_opcode = OP_ADD; nm_left = 32'd3; nm_right = 32'd4; nm_in_valid = 1'b1;
        @(posedge clk); #1;
        nm_in_valid = 1'b0;
        chk("nomul ADD result", nm_result, 32'd7);
        chk("nomul ADD illegal", {31'd0, nm_illegal}, 32'd0);
        nm_out_ready = 1'b1;
        @(posedge clk); #1;
        nm_out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a power of two, 8 to 64.
REQ-002 Parameter MUL_EN, default 1, 1 = sequential multiplier present, 0 = MUL/MULHU illegal.
REQ-003 Ports SHALL be, one per line: name direction width meaning.
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts request this cycle.
- opcode  input  4  operation select.
- left  input  WIDTH  operand A.
- right  input  WIDTH  operand B.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer takes result this cycle.
- result  output  WIDTH  operation result.
- illegal  output  1  qualifies result: opcode unsupported.

Function
REQ-004 Opcodes SHALL be: 0000 ADD, 0100 SUB, 0111 AND, 0110 OR, 0101 XOR, 0001 SLL, 1101 SRL, 1110 SRA, 0010 SLT (signed), 0011 SLTU, 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits, unsigned); all others illegal.
REQ-005 Handshake: request accepted on a cycle with in_valid && in_ready; operands and opcode SHALL be registered at acceptance and input changes after that SHALL NOT affect the result.
REQ-006 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state == IDLE).
REQ-007 IDLE -> DONE on acceptance of a single-cycle op (all except MUL/MULHU) or an illegal op; out_valid high the cycle after acceptance (latency 1).
REQ-008 IDLE -> BUSY on acceptance of MUL/MULHU with MUL_EN=1; BUSY lasts exactly WIDTH cycles (shift-add, one bit per cycle), then -> DONE; out_valid latency WIDTH+1 from acceptance.
REQ-009 DONE: result, illegal, out_valid held stable until out_valid && out_ready; then -> IDLE; out_ready while not out_valid SHALL be ignored.
REQ-010 Max throughput one op per 2 cycles (accept, then DONE/handshake); no acceptance in BUSY or DONE.
REQ-011 ADD/SUB SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-012 Shifts SHALL use right[log2(WIDTH)-1:0] only; upper bits of right ignored; SRA replicates left MSB.
REQ-013 SLT/SLTU SHALL return 1 zero-extended to WIDTH, else 0.
REQ-014 MUL/MULHU SHALL form the full 2*WIDTH unsigned product; MUL returns low half, MULHU high half.
REQ-015 Illegal opcode (incl. MUL/MULHU with MUL_EN=0): result = 0, illegal = 1, latency 1; legal ops illegal = 0.

Reset
REQ-016 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, illegal 0, multiplier counter/accumulator 0, independent of clk.
REQ-017 Reset during BUSY or DONE SHALL abandon the operation; no result delivered after release.
REQ-018 First acceptance possible on the first rising clk edge after rst_n deasserts.

Structure
REQ-019 Opcode constants and FSM state encodings SHALL live in shared package alu_pkg, reused by the existing combinational alu and its bench.
REQ-020 Sequential multiplier SHALL be sub-module alu_mul_seq (start, operands in; busy, done, 2*WIDTH product out; log2(WIDTH)+1-bit counter); omitted by generate when MUL_EN=0.
REQ-021 Single-cycle datapath SHALL be combinational from registered operands into the result register; no latches.

Verification
REQ-022 WIDTH=32: ADD 4,3 -> result 7, out_valid 1 cycle after acceptance; SUB 7,3 -> 4; SUB 0,1 -> 0xFFFFFFFF; AND 0b1100,0b1010 -> 0b1000.
REQ-023 SRA 0x80000000 by right=0x21 -> shift 1 -> 0xC0000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
REQ-024 MUL 0xFFFFFFFF,0xFFFFFFFF -> out_valid exactly 33 cycles after acceptance, result 0x00000001; MULHU same -> 0xFFFFFFFE; in_ready 0 throughout.
REQ-025 Backpressure: ADD 1,1 with out_ready 0 for 5 cycles -> result 2 and out_valid held stable, in_ready 0; out_ready 1 -> IDLE next cycle.
REQ-026 Opcode 1111 -> illegal 1, result 0; MUL_EN=0 build, MUL -> illegal 1 at latency 1.
REQ-027 rst_n pulsed low mid-BUSY of MUL -> out_valid 0 immediately, no stale result after release; next ADD 2,2 -> 4.
